// File: rtl/pea_pkg.sv
// pea_pkg: PE control word layout, idle word and sequencer state type shared by the PE array blocks.
`default_nettype none

package pea_pkg;

  localparam int CTRL_W = 11;

  // Control word layout, MSB first: output(3) op1(3) op2(3) opcode(2).
  localparam int OUT_W = 3;
  localparam int OP1_W = 3;
  localparam int OP2_W = 3;
  localparam int OPC_W = 2;

  localparam int OPC_LSB = 0;
  localparam int OP2_LSB = OPC_LSB + OPC_W;
  localparam int OP1_LSB = OP2_LSB + OP2_W;
  localparam int OUT_LSB = OP1_LSB + OP1_W;

  // An output field of 000 means no writeback, so the all-zero word is harmless.
  localparam logic [CTRL_W-1:0] NOP_CTRL = 11'b000_000_000_00;

  typedef enum logic [0:0] {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

  function automatic logic [CTRL_W-1:0] pe_ctrl_pack(
    input logic [OUT_W-1:0] out_f,
    input logic [OP1_W-1:0] op1_f,
    input logic [OP2_W-1:0] op2_f,
    input logic [OPC_W-1:0] opc_f
  );
    logic [CTRL_W-1:0] word;
    word = '0;
    word[OUT_LSB +: OUT_W] = out_f;
    word[OP1_LSB +: OP1_W] = op1_f;
    word[OP2_LSB +: OP2_W] = op2_f;
    word[OPC_LSB +: OPC_W] = opc_f;
    return word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_ctrl_sequencer.sv
// pe_ctrl_sequencer: replays a stored program of PE control words, each held HOLD cycles, with stall and looping.
// Looping over multiple passes is built only when PE_SEQ_LOOP_EN is defined.
`default_nettype none

module pe_ctrl_sequencer
  import pea_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int HOLD   = 5,
  parameter int LOOP_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we_i,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr_i,
  input  logic [CTRL_W-1:0]          cfg_data_i,
  input  logic                       start_i,
  input  logic [$clog2(DEPTH+1)-1:0] prog_len_i,
  input  logic [LOOP_W-1:0]          loop_cnt_i,
  input  logic                       stall_i,
  output logic [CTRL_W-1:0]          ctrl_o,
  output logic                       ctrl_valid_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [$clog2(DEPTH)-1:0]   pc_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [LW-1:0] LEN_MAX   = LW'(DEPTH);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

  logic [CTRL_W-1:0] mem_q [DEPTH];

  seq_state_t        state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [AW-1:0]     len_m1_q, len_m1_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              w_mem_we;
  logic              w_len_ok;
  logic [AW-1:0]     w_pc_inc;

`ifdef PE_SEQ_LOOP_EN
  logic [LOOP_W-1:0] pass_q, pass_d;
  logic [LOOP_W-1:0] loops_q, loops_d;
`else
  logic              w_unused_loop;
  assign w_unused_loop = ^loop_cnt_i;
`endif

  assign w_len_ok = (prog_len_i != '0) && (prog_len_i <= LEN_MAX);
  assign w_pc_inc = pc_q + AW'(1);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    hold_d   = hold_q;
    len_m1_d = len_m1_q;
    ctrl_d   = ctrl_q;
    done_d   = 1'b0;
    err_d    = err_q;
    w_mem_we = 1'b0;
`ifdef PE_SEQ_LOOP_EN
    pass_d   = pass_q;
    loops_d  = loops_q;
`endif
    unique case (state_q)
      SEQ_IDLE: begin
        pc_d   = '0;
        ctrl_d = NOP_CTRL;
        if (start_i) begin
          if (w_len_ok) begin
            state_d  = SEQ_RUN;
            hold_d   = '0;
            len_m1_d = AW'(prog_len_i - LW'(1));
            ctrl_d   = mem_q[0];
            err_d    = 1'b0;
`ifdef PE_SEQ_LOOP_EN
            pass_d   = '0;
            loops_d  = loop_cnt_i;
`endif
          end else begin
            err_d = 1'b1;
          end
          // A write colliding with start is dropped and flagged.
          if (cfg_we_i) begin
            err_d = 1'b1;
          end
        end else if (cfg_we_i) begin
          w_mem_we = 1'b1;
        end
      end
      SEQ_RUN: begin
        if (!stall_i) begin
          if (cfg_we_i) begin
            err_d = 1'b1;
          end
          if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + HW'(1);
          end else begin
            hold_d = '0;
            if (pc_q != len_m1_q) begin
              pc_d   = w_pc_inc;
              ctrl_d = mem_q[w_pc_inc];
`ifdef PE_SEQ_LOOP_EN
            end else if (pass_q != loops_q) begin
              pc_d   = '0;
              pass_d = pass_q + LOOP_W'(1);
              ctrl_d = mem_q[0];
`endif
            end else begin
              state_d = SEQ_IDLE;
              pc_d    = '0;
              done_d  = 1'b1;
              ctrl_d  = NOP_CTRL;
            end
          end
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEQ_IDLE;
      pc_q     <= '0;
      hold_q   <= '0;
      len_m1_q <= '0;
      ctrl_q   <= NOP_CTRL;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef PE_SEQ_LOOP_EN
      pass_q   <= '0;
      loops_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      hold_q   <= hold_d;
      len_m1_q <= len_m1_d;
      ctrl_q   <= ctrl_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef PE_SEQ_LOOP_EN
      pass_q   <= pass_d;
      loops_q  <= loops_d;
`endif
    end
  end

  // Program memory is deliberately outside reset so a program survives a reset.
  always_ff @(posedge clk) begin
    if (!rst && w_mem_we) begin
      mem_q[cfg_addr_i] <= cfg_data_i;
    end
  end

  assign ctrl_o       = ctrl_q;
  assign ctrl_valid_o = (state_q == SEQ_RUN);
  assign busy_o       = (state_q == SEQ_RUN);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign pc_o         = pc_q;

endmodule

`default_nettype wire

// File: doc/pe_ctrl_sequencer.md
# pe_ctrl_sequencer

Context sequencer directly upstream of a PE: holds a small program of 11-bit PE control words and drives the PE `ctrl` input one word at a time, in place of the hand-driven `ctrl` changes used in PE bring-up. Each word is held for a fixed number of cycles, matching the PE's multi-cycle register update. The program can be looped and frozen with `stall`. Once started, it runs without further host input.

## Interface
- `DEPTH`, 16: program memory entries.
- `CTRL_W`, 11: control word width; format output(3)\_op1(3)\_op2(3)\_opcode(2).
- `HOLD`, 5: cycles each word is presented, ≥1.
- `LOOP_W`, 8: width of the loop count.
- `NOP_CTRL`, 11'b000_000_000_00: word driven when not running; output field 000 means no writeback.
- `clk`  in  1: the block's single clock.
- `rst`  in  1: synchronous, active-high reset.
- `cfg_we`  in  1: program write strobe.
- `cfg_addr`  in  $clog2(DEPTH): write address.
- `cfg_data`  in  CTRL_W: word to write.
- `start`  in  1: begin a run; level-sampled, accepted only in IDLE.
- `prog_len`  in  $clog2(DEPTH+1): words per pass, valid range 1..DEPTH; sampled on the accepting edge.
- `loop_cnt`  in  LOOP_W: extra passes; total passes = loop_cnt+1; sampled on the accepting edge.
- `stall`  in  1: freeze the run.
- `ctrl`  out  CTRL_W: to PE `ctrl`.
- `ctrl_valid`  out  1: `ctrl` carries a program word.
- `busy`  out  1: state is RUN.
- `done`  out  1: one-cycle pulse after the final word.
- `err`  out  1: sticky error flag.
- `pc`  out  $clog2(DEPTH): index of the word currently on `ctrl`.

## Operation
- States: IDLE, RUN.
- IDLE, `start`=1, prog_len in 1..DEPTH: go to RUN; pc=0, hold=0, pass=0; `ctrl`=mem[0]; clear `err`.
- IDLE, `start`=1, prog_len=0 or >DEPTH: stay in IDLE, set `err`.
- RUN, `stall`=0:
  - hold<HOLD-1: hold++.
  - Otherwise hold=0, then:
    - pc<prog_len-1: pc++.
    - Otherwise, pass<loop_cnt: pc=0, pass++.
    - Otherwise: go to IDLE, `done`=1 for one cycle, `ctrl`=NOP_CTRL.
- RUN, `stall`=1: all state and outputs frozen. `stall` is ignored in IDLE.
- `cfg_we` in IDLE, with `start`=0: mem[cfg_addr]=cfg_data.
- `cfg_we` in RUN, or in the same cycle as `start`: write dropped, `err` set. `start` has priority.
- `start` in RUN: ignored; no error.
- Issued words per run = prog_len·(loop_cnt+1). Active cycles = that count·HOLD, plus stall cycles.
- `pc` is 0 in IDLE.

## Timing
- Reset values: `ctrl`=NOP_CTRL; `ctrl_valid`, `busy`, `done`, `err`=0; `pc`=0; state IDLE.
- Reset does not clear the program memory. Reset mid-run returns to IDLE at the next edge with no `done` pulse.
- All outputs are registered.
- `ctrl` shows mem[0] in the cycle after the edge that samples `start`.
- Each word is held exactly HOLD cycles when there is no stall.
- `done` is high in the first IDLE cycle. `start` is accepted in that cycle, so back-to-back runs have a one-cycle NOP gap.
- `busy` equals `ctrl_valid`.
- A word written at edge t is visible to a run started at edge ≥t+1.

## Configuration
- `PE_SEQ_LOOP_EN` defined: looping as described.
- Undefined: `loop_cnt` is ignored and treated as 0 (single pass). The pass counter is not synthesized, and the port remains for a stable interface.

## Structure
- Shared package `pea_pkg`:
  - `CTRL_W`.
  - Field widths and offsets (output, op1, op2, opcode).
  - `NOP_CTRL`.
  - State enum `seq_state_t`.
- No sub-module: the memory is an inline register array with a synchronous write and a registered read into `ctrl`.

## Test plan
- Load `101_000_001_00`, `110_100_010_10`, `100_101_100_11`; prog_len=3, loop_cnt=0, HOLD=5 → each word on `ctrl` for 5 cycles with pc 0,1,2; `done` pulses at cycle 16 after start; then NOP.
- Same program with loop_cnt=2 → 9 words in order 0,1,2 ×3; 45 active cycles; a single `done`.
- Assert `stall` for 4 cycles mid-word 1 → word 1 held 9 cycles total; `done` delayed by 4.
- start with prog_len=0 → stays IDLE, `err`=1; a following valid start clears `err`. `cfg_we` during RUN → memory unchanged, `err`=1.
- `rst` at cycle 7 of a run → next cycle `ctrl`=NOP, busy=0, no `done`. A restart replays the original program, showing memory is retained.
- Without `PE_SEQ_LOOP_EN`, loop_cnt=3 → single pass, 3 words.
